prince_core_sequencer: RTL
==========================

// Module: prince_core_sequencer
// PURPOSE
//   Host-side driver for the masked PRINCE round pipeline: accepts one shared plaintext/key
//   via valid/ready, launches the core by pulsing its round-controller reset (start/load),
//   waits for the controller's done, captures the shared ciphertext and returns it via
//   valid/ready. Sits between the system bus wrapper and the PRINCE core + round controller.
// PARAMETERS
//   SHARES       2    number of Boolean shares per datum (data width 64*SHARES, key 128*SHARES)
//   START_CYCLES 1    cycles core_start is held high per launch (>=1)
//   MAX_LATENCY  96   cycles after start release before a missing core_done is flagged
// PORTS
//   clk        in   1             rising-edge clock
//   reset      in   1             asynchronous, active-high reset
//   in_valid   in   1             host offers pt/key
//   in_ready   out  1             sequencer can accept (high only in IDLE)
//   in_pt      in   64*SHARES     shared plaintext
//   in_key     in   128*SHARES    shared key
//   core_start out  1             drives core controller reset / roundStart_Select
//   core_pt    out  64*SHARES     registered plaintext, stable from accept until next accept
//   core_key   out  128*SHARES    registered key, stable from accept until next accept
//   core_done  in   1             controller done (combinational level from core)
//   core_ct    in   64*SHARES     core ciphertext shares, valid while core_done=1
//   out_valid  out  1             ciphertext available
//   out_ready  in   1             host consumes ciphertext
//   out_ct     out  64*SHARES     registered ciphertext shares
//   out_err    out  1             qualifies out_valid: 1 = timeout, out_ct forced to 0
//   busy       out  1             high in START and RUN
// BEHAVIOUR
//   - Reset (async): state=IDLE, core_start=0, out_valid=0, out_err=0, out_ct=0,
//     core_pt/core_key=0, counters=0. Reset mid-operation aborts silently, no output produced.
//   - FSM states IDLE, START, RUN, OUT; all outputs registered except in_ready (=state==IDLE).
//   - IDLE: on in_valid&in_ready capture in_pt/in_key into core_pt/core_key, go START.
//   - START: core_start=1 for exactly START_CYCLES cycles (first cycle is the one after
//     accept); core_done ignored; then core_start=0, cycle counter cleared, go RUN.
//   - RUN: counter increments each cycle (width clog2(MAX_LATENCY+1), saturating).
//     First cycle with core_done=1: out_ct<=core_ct, out_err<=0, go OUT.
//     If counter reaches MAX_LATENCY without done: out_ct<=0, out_err<=1, go OUT.
//     done and timeout in same cycle: done wins (err=0).
//   - OUT: out_valid=1, out_ct/out_err held until out_valid&out_ready; that cycle go IDLE,
//     out_valid falls next cycle. in_ready stays 0 in OUT (no overlap, one op in flight).
//   - Latency accept->out_valid = START_CYCLES + core latency + 1 cycle.
//   - core_done level held high after completion is ignored outside RUN; core_pt/core_key never
//     change while busy, so shares seen by the core are stable for the whole operation.
//   - Shares are passed through untouched; never combined (no unmasking anywhere in block).
// TESTING
//   1. Reset, then in_valid with pt shares {64'h0123456789abcdef,64'h0} and model core asserting
//      done 48 cycles after start -> core_start high 1 cycle, out_valid at cycle 50, out_err=0,
//      out_ct equals model ct.
//   2. out_ready held low 10 cycles in OUT -> out_valid/out_ct stable, in_ready=0 throughout;
//      release -> IDLE, in_ready=1 next cycle.
//   3. Model never asserts done -> out_valid with out_err=1, out_ct=0 exactly MAX_LATENCY
//      cycles after start release.
//   4. core_done held high during START and after OUT -> ignored; only RUN edge captured.
//   5. Async reset asserted in RUN cycle 20 -> all outputs zero immediately, no out_valid after
//      deassert; new request completes normally.
//   6. Back-to-back requests with in_valid always high, START_CYCLES=3 -> each op accepted only
//      in IDLE, core_start 3 cycles wide, ciphertexts returned in order.

Source files
------------

// File: rtl/prince_core_sequencer.sv
// ---------------------------------------------------------------------------
// prince_core_sequencer
//
// Host-side driver for the masked PRINCE round pipeline. It accepts one
// shared plaintext/key pair from the host, launches the core by pulsing the
// round controller's start/load input, and waits for the controller's done.
// It then captures the shared ciphertext and returns it to the host. Only
// one operation is in flight at a time.
//
// The shares are passed through untouched and are never combined, so no
// unmasked value appears anywhere in this block.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   host offers in_pt/in_key
//   in_ready   sequencer can accept (idle only, combinational from state)
//   in_pt      shared plaintext (64*SHARES)
//   in_key     shared key (128*SHARES)
//   core_start start/load pulse to the core's round controller
//   core_pt    registered plaintext; stable from one accept to the next
//   core_key   registered key; stable from one accept to the next
//   core_done  done level from the core's controller
//   core_ct    core ciphertext shares, valid while core_done is high
//   out_valid  ciphertext (or error) available to the host
//   out_ready  host consumes the result
//   out_ct     registered ciphertext shares (zero on timeout)
//   out_err    qualifies out_valid: 1 = core never reported done
//   busy       high while the core is being started or is running
// ---------------------------------------------------------------------------
module prince_core_sequencer #(
    parameter int SHARES       = 2,
    parameter int START_CYCLES = 1,
    parameter int MAX_LATENCY  = 96
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [64*SHARES-1:0]    in_pt,
    input  logic [128*SHARES-1:0]   in_key,
    output logic                    core_start,
    output logic [64*SHARES-1:0]    core_pt,
    output logic [128*SHARES-1:0]   core_key,
    input  logic                    core_done,
    input  logic [64*SHARES-1:0]    core_ct,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [64*SHARES-1:0]    out_ct,
    output logic                    out_err,
    output logic                    busy
);

    localparam int DW = 64 * SHARES;
    localparam int KW = 128 * SHARES;
    localparam int CW = $clog2(MAX_LATENCY + 1);
    localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        OUT
    } stateT;

    stateT          state;
    stateT          nextState;
    logic [SW-1:0]  startCnt;
    logic [CW-1:0]  runCnt;
    logic [CW-1:0]  runCntInc;
    logic           accept;
    logic           startDone;
    logic           timeout;
    logic           takeCt;
    logic           takeErr;

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && (state == IDLE);
    assign startDone = (startCnt == SW'(START_CYCLES - 1));

    // The run counter saturates so it can never wrap back into a value that
    // looks like a fresh run.
    assign runCntInc = (runCnt == CW'(MAX_LATENCY)) ? runCnt : runCnt + 1'b1;
    assign timeout   = (runCntInc == CW'(MAX_LATENCY));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. core_done is only looked at in RUN, so a done level
    // the core keeps holding after completion, or a glitch while the
    // controller is still being loaded, can never complete an operation.
    // When done and timeout coincide, done takes priority.
    always_comb begin
        nextState = state;
        takeCt    = 1'b0;
        takeErr   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = START;
                end
            end
            START: begin
                if (startDone) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (core_done) begin
                    takeCt    = 1'b1;
                    nextState = OUT;
                end else if (timeout) begin
                    takeErr   = 1'b1;
                    nextState = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs. The control outputs are derived from
    // nextState so that each one changes on the same edge as the state
    // transition that causes it. core_pt/core_key load only on accept, so
    // the core sees stable shares for the whole operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_pt    <= '0;
            core_key   <= '0;
            startCnt   <= '0;
            runCnt     <= '0;
            out_ct     <= '0;
            out_err    <= 1'b0;
            core_start <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (accept) begin
                core_pt  <= in_pt;
                core_key <= in_key;
            end
            startCnt <= (state == START) ? startCnt + 1'b1 : '0;
            runCnt   <= (state == RUN) ? runCntInc : '0;
            if (takeCt) begin
                out_ct  <= core_ct;
                out_err <= 1'b0;
            end else if (takeErr) begin
                out_ct  <= '0;
                out_err <= 1'b1;
            end
            core_start <= (nextState == START);
            out_valid  <= (nextState == OUT);
            busy       <= (nextState == START) || (nextState == RUN);
        end
    end

endmodule
